seq_divider: RTL and testbench

- Multi-cycle unsigned radix-2 restoring divider; the inverse operation of the team's combinational array/tree multipliers.
- Computes quotient and remainder of a DW-bit dividend by a VW-bit divisor, one quotient bit per clock.
- Valid/ready handshakes on input and output, so it can sit behind the multiplier datapath and feed result-checking or normalisation logic.
- Used for round-trip checks of multiplier outputs: product / y must return x with zero remainder.

---
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned radix-2 restoring divider.
// Produces one quotient bit per clock. Valid/ready handshakes are used on both the
// operand side and the result side. A zero divisor skips the iteration and
// returns an all-ones quotient with div_by_zero set.
module seq_divider #(
    parameter int DW = 8,   // dividend / quotient width
    parameter int VW = 4    // divisor / remainder width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // The step counter only has to hold values 0..DW-1.
    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [VW:0]   wrem_reg, wrem_next;     // working remainder, one guard bit
    logic [DW-1:0] q_reg, q_next;           // dividend in, quotient out (shift register)
    logic [VW-1:0] dvs_reg, dvs_next;       // divisor held for the whole operation
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] quotient_next;
    logic [VW-1:0] remainder_next;
    logic          dbz_next;

    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          fits;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The guard bit is always 0 because the
    // remainder stays below the divisor. If it were ever set, the trial value
    // would still be at least the divisor.
    always_comb begin
        trial = {wrem_reg[VW-1:0], q_reg[DW-1]};
        diff  = trial - {1'b0, dvs_reg};
        fits  = wrem_reg[VW] | (trial >= {1'b0, dvs_reg});
    end

    // Next-state and datapath update for the IDLE / RUN / DONE sequence.
    always_comb begin
        state_next     = state_reg;
        wrem_next      = wrem_reg;
        q_next         = q_reg;
        dvs_next       = dvs_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient;
        remainder_next = remainder;
        dbz_next       = div_by_zero;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        state_next     = DONE;
                        quotient_next  = '1;
                        remainder_next = '0;
                        dbz_next       = 1'b1;
                    end else begin
                        state_next = RUN;
                        q_next     = dividend;
                        dvs_next   = divisor;
                        wrem_next  = '0;
                        cnt_next   = '0;
                    end
                end
            end
            RUN: begin
                wrem_next = fits ? diff : trial;
                q_next    = {q_reg[DW-2:0], fits};
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP) begin
                    state_next     = DONE;
                    quotient_next  = {q_reg[DW-2:0], fits};
                    remainder_next = fits ? diff[VW-1:0] : trial[VW-1:0];
                    dbz_next       = 1'b0;
                end
            end
            DONE: begin
                // Data outputs keep their values after handoff. Only the flag clears.
                if (out_ready) begin
                    state_next = IDLE;
                    dbz_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            wrem_reg    <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            cnt_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wrem_reg    <= wrem_next;
            q_reg       <= q_next;
            dvs_reg     <= dvs_next;
            cnt_reg     <= cnt_next;
            quotient    <= quotient_next;
            remainder   <= remainder_next;
            div_by_zero <= dbz_next;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider. A cycle-level behavioural model built on integer
// / and % is checked against the DUT on every negative edge. Directed operations
// pin literal results, latency, backpressure and reset. An exhaustive operand
// sweep with random out_ready checks the exactness identity.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: phase, remaining cycles and the expected result.
    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_DONE = 2;

    int            m_phase;
    int            m_left;
    logic [DW-1:0] m_n;
    logic [VW-1:0] m_d;
    logic [DW-1:0] m_q;
    logic [VW-1:0] m_r;
    logic          m_z;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE;
            m_left  <= 0;
            m_n     <= '0;
            m_d     <= '0;
            m_q     <= '0;
            m_r     <= '0;
            m_z     <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (in_valid) begin
                    if (divisor == 0) begin
                        m_phase <= P_DONE;
                        m_q     <= '1;
                        m_r     <= '0;
                        m_z     <= 1'b1;
                    end else begin
                        m_phase <= P_BUSY;
                        m_left  <= DW;
                        m_n     <= dividend;
                        m_d     <= divisor;
                    end
                end
                P_BUSY: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= P_DONE;
                        m_q     <= DW'(m_n / m_d);
                        m_r     <= VW'(m_n % m_d);
                        m_z     <= 1'b0;
                    end
                end
                default: if (out_ready) begin
                    m_phase <= P_IDLE;
                    m_z     <= 1'b0;
                end
            endcase
        end
    end

    // Per-cycle comparison of the handshake outputs and, while a result is held, the data outputs.
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_phase == P_IDLE);
        chk("out_valid", out_valid, m_phase == P_DONE);
        if (m_phase == P_DONE) begin
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", div_by_zero, m_z);
        end else begin
            chk("div_by_zero_idle", div_by_zero, 1'b0);
        end
    end

    // Present operands until accepted. Returns at the negedge right after the accept edge.
    task automatic send(input logic [DW-1:0] n, input logic [VW-1:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = n;
        divisor   = d;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", guard, 0);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    // Take the result, with optionally random backpressure. Returns after the handoff edge.
    task automatic receive(input logic [DW-1:0] n, input logic [VW-1:0] d, input bit rnd);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            guard++;
        end while (!(out_valid && out_ready) && guard < 200);
        if (guard >= 200) begin
            chk("result_timeout", guard, 0);
        end else begin
            if (d != 0) begin
                chk("identity", 64'(quotient) * 64'(d) + 64'(remainder), 64'(n));
                chk("rem_lt_div", remainder < d, 1'b1);
                chk("dbz_clear", div_by_zero, 1'b0);
            end else begin
                chk("dbz_set", div_by_zero, 1'b1);
                chk("dbz_quot", quotient, {DW{1'b1}});
                chk("dbz_rem", remainder, 0);
            end
            $display("op n=%0d d=%0d q=%0d r=%0d z=%0d", n, d, quotient, remainder, div_by_zero);
        end
        @(posedge clk);
    endtask

    // Directed operation with literal expectations and a latency check.
    task automatic directed(input logic [DW-1:0] n, input logic [VW-1:0] d,
                            input int eq, input int er, input int elat);
        int lat;
        send(n, d);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, elat);
        chk("lit_quotient", quotient, eq);
        chk("lit_remainder", remainder, er);
        chk("lit_dbz", div_by_zero, d == 0);
        receive(n, d, 1'b0);
    endtask

    initial begin
        int guard;
        logic [DW-1:0] q_hold;
        logic [VW-1:0] r_hold;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;

        // Literal results and latency.
        directed(8'd200, 4'd13, 15, 5, DW);
        directed(8'd255, 4'd1, 255, 0, DW);
        directed(8'd7, 4'd9, 0, 7, DW);
        directed(8'h5A, 4'd0, 255, 0, 0);
        @(negedge clk);
        chk("dbz_after_handoff", div_by_zero, 1'b0);
        chk("idle_after_handoff", out_valid, 1'b0);

        // Backpressure with a pending operand.
        send(8'd100, 4'd7);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_reach_done", out_valid, 1'b1);
        in_valid  = 1'b1;
        dividend  = 8'd77;
        divisor   = 4'd5;
        out_ready = 1'b0;
        q_hold    = quotient;
        r_hold    = remainder;
        chk("bp_quot_val", q_hold, 14);
        chk("bp_rem_val", r_hold, 2);
        repeat (10) begin
            @(negedge clk);
            chk("bp_quot_stable", quotient, q_hold);
            chk("bp_rem_stable", remainder, r_hold);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_handoff_valid", out_valid, 1'b0);
        chk("bp_handoff_ready", in_ready, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_accepted", in_ready, 1'b0);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_next_quot", quotient, 15);
        chk("bp_next_rem", remainder, 2);
        receive(8'd77, 4'd5, 1'b0);

        // Asynchronous reset in the middle of an operation.
        send(8'd200, 4'd13);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_dbz", div_by_zero, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("no_stale_result", out_valid, 1'b0);
        end

        // Exhaustive sweep with random backpressure.
        for (int n = 0; n < (1 << DW); n++) begin
            for (int d = 0; d < (1 << VW); d++) begin
                send(DW'(n), VW'(d));
                receive(DW'(n), VW'(d), 1'b1);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
